// File: rtl/ring_router_pkg.sv
// Shared constants and routing helpers for the multicast ring router.
// Port indices, destination-mask routing and per-port mask trimming.
package ring_router_pkg;

  localparam logic [1:0]  PORT_E    = 2'd0;
  localparam logic [1:0]  PORT_W    = 2'd1;
  localparam logic [1:0]  PORT_L    = 2'd2;
  localparam int unsigned NUM_PORTS = 3;
  localparam int unsigned MAX_NODES = 64;

  typedef logic [MAX_NODES-1:0] node_mask_t;
  typedef logic [NUM_PORTS-1:0] port_set_t;

  // Output port that carries traffic for one destination node.
  function automatic logic [1:0] node_port(input int unsigned node,
                                           input int unsigned local_id,
                                           input int unsigned nodes);
    int unsigned d;
    d = (node + nodes - local_id) % nodes;
    if (d == 0) begin
      return PORT_L;
    end else if (d <= nodes / 2) begin
      return PORT_E;
    end
    return PORT_W;
  endfunction

  function automatic port_set_t route_mask(input node_mask_t  mask,
                                           input int unsigned local_id,
                                           input int unsigned nodes);
    port_set_t  ports;
    node_mask_t m;
    ports = '0;
    for (int unsigned k = 0; k < MAX_NODES; k++) begin
      m = mask >> k;
      if (k < nodes && m[0]) begin
        ports[node_port(k, local_id, nodes)] = 1'b1;
      end
    end
    return ports;
  endfunction

  // Keep only the destinations reached through the given output port.
  function automatic node_mask_t trim_mask(input node_mask_t  mask,
                                           input logic [1:0]  port,
                                           input int unsigned local_id,
                                           input int unsigned nodes);
    node_mask_t t;
    node_mask_t m;
    t = '0;
    for (int unsigned k = 0; k < MAX_NODES; k++) begin
      m = mask >> k;
      if (k < nodes && m[0] && node_port(k, local_id, nodes) == port) begin
        t = t | (node_mask_t'(1) << k);
      end
    end
    return t;
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/ring_fifo.sv
// Synchronous show-ahead FIFO with registered full / almost-full flags.
module ring_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             afull
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, afull_q;
  logic             do_push, do_pop;

  // A write into a full FIFO is dropped even if the head leaves this cycle.
  assign do_push = push && !full_q;
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      afull_q <= (count_d >= CW'(DEPTH - 1));
    end
  end

  assign dout  = mem[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = full_q;
  assign afull = afull_q;

endmodule

// File: rtl/ring_mcast_router.sv
// Three-port (East/West/Local) multicast ring router with per-output round-robin arbitration.
// Define RING_ROUTER_PERF_EN to add per-output forward and stall counters.
module ring_mcast_router
  import ring_router_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NODES    = 4,
  parameter int unsigned LOCAL_ID = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_e,
  input  logic             write_w,
  input  logic             write_l,
  input  logic [WIDTH-1:0] data_in_e,
  input  logic [WIDTH-1:0] data_in_w,
  input  logic [WIDTH-1:0] data_in_l,
  input  logic             ds_full_e,
  input  logic             ds_full_w,
  input  logic             ds_full_l,
  input  logic             ds_afull_e,
  input  logic             ds_afull_w,
  input  logic             ds_afull_l,
  output logic [WIDTH-1:0] data_out_e,
  output logic [WIDTH-1:0] data_out_w,
  output logic [WIDTH-1:0] data_out_l,
  output logic             write_out_e,
  output logic             write_out_w,
  output logic             write_out_l,
`ifdef RING_ROUTER_PERF_EN
  output logic [31:0]      fwd_cnt_e,
  output logic [31:0]      fwd_cnt_w,
  output logic [31:0]      fwd_cnt_l,
  output logic [31:0]      stall_cnt_e,
  output logic [31:0]      stall_cnt_w,
  output logic [31:0]      stall_cnt_l,
`endif
  output logic             full_e,
  output logic             full_w,
  output logic             full_l,
  output logic             afull_e,
  output logic             afull_w,
  output logic             afull_l
);

  // Bits of a flit that hold the destination mask.
  localparam logic [WIDTH-1:0] MaskField = ((WIDTH'(1) << NODES) - WIDTH'(1)) << 1;

  logic [WIDTH-1:0]     in_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_write, ds_full, ds_afull;
  logic [WIDTH-1:0]     head [NUM_PORTS];
  logic [NUM_PORTS-1:0] empty, pop, fifo_full, fifo_afull;
  node_mask_t           head_mask [NUM_PORTS];
  port_set_t            req [NUM_PORTS];
  port_set_t            granted [NUM_PORTS];
  logic [WIDTH-1:0]     copy [NUM_PORTS][NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt_vld, wr_out;
  logic [1:0]           gnt_src [NUM_PORTS];
  logic [WIDTH-1:0]     dout [NUM_PORTS];
`ifdef RING_ROUTER_PERF_EN
  logic [31:0]          fwd_cnt [NUM_PORTS];
  logic [31:0]          stall_cnt [NUM_PORTS];
`endif

  assign in_data[PORT_E] = data_in_e;
  assign in_data[PORT_W] = data_in_w;
  assign in_data[PORT_L] = data_in_l;
  assign in_write = {write_l, write_w, write_e};
  assign ds_full  = {ds_full_l, ds_full_w, ds_full_e};
  assign ds_afull = {ds_afull_l, ds_afull_w, ds_afull_e};

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    port_set_t pend_q, pend_d, route, eff_pend, remain;
    logic      pend_vld_q, pend_vld_d;

    ring_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (in_write[i] && in_data[i][0]),
      .pop  (pop[i]),
      .din  (in_data[i]),
      .dout (head[i]),
      .empty(empty[i]),
      .full (fifo_full[i]),
      .afull(fifo_afull[i])
    );

    assign head_mask[i] = node_mask_t'(head[i][NODES:1]);
    assign route        = route_mask(head_mask[i], LOCAL_ID, NODES);
    // A fresh head is routed combinationally; afterwards the stored pending set is used.
    assign eff_pend     = pend_vld_q ? pend_q : route;
    assign req[i]       = empty[i] ? '0 : eff_pend;
    assign remain       = eff_pend & ~granted[i];
    assign pop[i]       = !empty[i] && (remain == '0);

    always_comb begin
      pend_d     = remain;
      pend_vld_d = 1'b1;
      if (empty[i] || pop[i]) begin
        pend_d     = '0;
        pend_vld_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        pend_q     <= '0;
        pend_vld_q <= 1'b0;
      end else begin
        pend_q     <= pend_d;
        pend_vld_q <= pend_vld_d;
      end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_copy
      logic [NODES-1:0] trimmed;
      assign trimmed       = NODES'(trim_mask(head_mask[i], 2'(p), LOCAL_ID, NODES));
      assign copy[p][i]    = (head[i] & ~MaskField) | (WIDTH'(trimmed) << 1);
      assign granted[i][p] = gnt_vld[p] && (gnt_src[p] == 2'(i));
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
    logic [NUM_PORTS-1:0] r;
    logic [1:0]           ptr_q, c0, c1, c2, src;
    logic                 vld, elig, wr_q;
    logic [WIDTH-1:0]     data_q;

    assign r    = {req[2][p], req[1][p], req[0][p]};
    assign elig = !ds_full[p] && !(ds_afull[p] && wr_q);
    assign c0   = ptr_q;
    assign c1   = rr_next(c0);
    assign c2   = rr_next(c1);

    always_comb begin
      vld = 1'b0;
      src = c0;
      if (elig) begin
        if (r[c0]) begin
          vld = 1'b1;
          src = c0;
        end else if (r[c1]) begin
          vld = 1'b1;
          src = c1;
        end else if (r[c2]) begin
          vld = 1'b1;
          src = c2;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        ptr_q  <= '0;
        data_q <= '0;
        wr_q   <= 1'b0;
      end else begin
        wr_q <= vld;
        if (vld) begin
          data_q <= copy[p][src];
          ptr_q  <= rr_next(src);
        end
      end
    end

    assign gnt_vld[p] = vld;
    assign gnt_src[p] = src;
    assign dout[p]    = data_q;
    assign wr_out[p]  = wr_q;

`ifdef RING_ROUTER_PERF_EN
    logic [31:0] fwd_q, stall_q;

    always_ff @(posedge clk) begin
      if (!reset) begin
        fwd_q   <= '0;
        stall_q <= '0;
      end else begin
        if (wr_q) begin
          fwd_q <= fwd_q + 32'd1;
        end
        if ((r != '0) && !elig) begin
          stall_q <= stall_q + 32'd1;
        end
      end
    end

    assign fwd_cnt[p]   = fwd_q;
    assign stall_cnt[p] = stall_q;
`endif
  end

  assign data_out_e  = dout[PORT_E];
  assign data_out_w  = dout[PORT_W];
  assign data_out_l  = dout[PORT_L];
  assign write_out_e = wr_out[PORT_E];
  assign write_out_w = wr_out[PORT_W];
  assign write_out_l = wr_out[PORT_L];
  assign full_e      = fifo_full[PORT_E];
  assign full_w      = fifo_full[PORT_W];
  assign full_l      = fifo_full[PORT_L];
  assign afull_e     = fifo_afull[PORT_E];
  assign afull_w     = fifo_afull[PORT_W];
  assign afull_l     = fifo_afull[PORT_L];

`ifdef RING_ROUTER_PERF_EN
  assign fwd_cnt_e   = fwd_cnt[PORT_E];
  assign fwd_cnt_w   = fwd_cnt[PORT_W];
  assign fwd_cnt_l   = fwd_cnt[PORT_L];
  assign stall_cnt_e = stall_cnt[PORT_E];
  assign stall_cnt_w = stall_cnt[PORT_W];
  assign stall_cnt_l = stall_cnt[PORT_L];
`endif

endmodule

// File: doc/ring_mcast_router.md
# ring_mcast_router

Parametrised successor to the 3-port ring router. It routes multicast flits on a unidirectional-addressed ring of `NODES` nodes through East, West and Local ports, with an input FIFO per port and a per-output round-robin arbiter. Partially delivered multicast flits are tracked per output port and are never dropped. The block sits at every ring stop between the two neighbour routers and the local IP.

## Interface
- `WIDTH`, 16: flit width. Bit 0 is the valid bit; bits `[NODES:1]` are the destination mask (bit `k+1` means node `k`). Requires `WIDTH >= NODES+1`.
- `DEPTH`, 32: entries per input FIFO, power of two, at least 4.
- `NODES`, 4: ring size, 3..`WIDTH-1`.
- `LOCAL_ID`, 1: this node's id, `0..NODES-1`.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset.
- `write_e`, `write_w`, `write_l`  in  1  enqueue strobe per input port.
- `data_in_e`, `data_in_w`, `data_in_l`  in  `WIDTH`  input flit per port.
- `ds_full_e`, `ds_full_w`, `ds_full_l`  in  1  downstream FIFO full.
- `ds_afull_e`, `ds_afull_w`, `ds_afull_l`  in  1  downstream FIFO almost full.
- `data_out_e`, `data_out_w`, `data_out_l`  out  `WIDTH`  registered output flit.
- `write_out_e`, `write_out_w`, `write_out_l`  out  1  registered write strobe to downstream.
- `full_e`, `full_w`, `full_l`  out  1  own input FIFO full (count == `DEPTH`).
- `afull_e`, `afull_w`, `afull_l`  out  1  own input FIFO almost full (count >= `DEPTH-1`).

## Operation
- Enqueue:
  - The write is accepted only if the strobe is high, flit bit 0 is 1 and the FIFO is not full.
  - A write to a full FIFO is dropped and the count is unchanged.
  - Simultaneous enqueue and dequeue on one FIFO is legal, including when full or empty.
- Routing: forward distance `d = (k - LOCAL_ID) mod NODES`.
  - `d == 0` goes Local.
  - `1 <= d <= NODES/2` (integer division) goes East.
  - Otherwise goes West.
  - Example: `NODES=4`, `LOCAL_ID=1`. Node 2 goes East, node 3 goes East, node 0 goes West.
- Pending set: each input holds a 3-bit `pend` register.
  - When a new flit reaches the FIFO head, `pend` is loaded with the union of the routes of its mask bits.
  - Each grant clears that port's bit in `pend`.
  - The flit is dequeued in the cycle its last pending bit is granted.
  - A valid flit with an all-zero mask is dequeued and discarded without output.
- Per-output copy: the mask of each output copy is trimmed to only the destinations routed through that port. This prevents duplicate delivery around the ring.
- Output eligibility: output `p` may be granted in a cycle iff `!ds_full_p && !(ds_afull_p && write_out_p)`.
- Arbitration:
  - Each output has its own round-robin pointer over inputs E=0, W=1, L=2.
  - The highest-priority requesting input wins.
  - After a grant, that output's pointer moves to the granted input + 1 (mod 3).
  - The pointer is unchanged when there is no grant.
  - One input may win several outputs in the same cycle.
- Output register: loads the granted copy and sets `write_out_p = 1`. With no grant, `write_out_p = 0` and `data_out_p` holds its previous value.
- Reset (while `reset == 0` at the edge):
  - FIFOs are emptied, `pend` is cleared and pointers are set to 0.
  - All outputs go to 0.
  - This applies mid-packet as well; in-flight flits are lost.

## Timing
- A flit enqueued at edge t is visible at the FIFO head (show-ahead) after edge t.
- It is arbitrated combinationally in cycle t..t+1.
- If uncontended, `write_out` is high in the cycle after edge t+1, so latency is 2 edges.
- A multicast to k output ports with no contention produces all k copies in the same cycle.
- `full`/`afull` are registered. They reflect the count after edge t in the cycle following edge t.
- Under continuous eligibility, each output sustains 1 flit per cycle.

## Configuration
- `RING_ROUTER_PERF_EN` defined:
  - Adds outputs `fwd_cnt_e`, `fwd_cnt_w`, `fwd_cnt_l` (32-bit each), counting `write_out` pulses.
  - Adds outputs `stall_cnt_e`, `stall_cnt_w`, `stall_cnt_l` (32-bit each), counting cycles where a request was present but the output was ineligible.
  - All counters wrap at 2^32 and clear on reset.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- `ring_router_pkg` holds:
  - Port index constants `PORT_E=0`, `PORT_W=1`, `PORT_L=2`.
  - The `route_mask(mask, LOCAL_ID, NODES)` function, returning a 3-bit port set.
  - The `trim_mask(mask, port, LOCAL_ID, NODES)` function.
- Sub-module `ring_fifo`: synchronous show-ahead FIFO with count, `full` and `afull`, instantiated three times.

## Test plan
- Unicast: `NODES=4`, `LOCAL_ID=1`, L input mask `0b0100` (node 2). Expect a single `write_out_e` pulse 2 edges later with unchanged data; W and L outputs silent.
- Multicast split: E input mask `0b1111`. Expect the same cycle:
  - `data_out_l` with mask `0b0010`.
  - `data_out_e` with mask `0b1100`.
  - `data_out_w` with mask `0b0001`.
  - FIFO dequeued once.
- Partial block: hold `ds_full_w=1` and send mask `0b0011`. Expect the L copy at once and the W copy only after `ds_full_w` drops. No duplicate L copy, and the next flit is not dequeued until then.
- Fairness: E, W and L all stream flits to node 1 (Local). Expect `write_out_l` grants to rotate E, W, L, E… with 1 flit per cycle.
- FIFO limits: write 33 flits into E with all outputs blocked. Expect `afull_e` at count 31, `full_e` at 32, and the 33rd flit dropped. Release the outputs and exactly 32 flits emerge in order.
- Reset mid-stream: assert `reset=0` for 1 cycle during traffic. The next cycle shows all outputs 0 and all FIFOs empty.
